// File: rtl/ival_loader.sv
// Framed byte-stream loader: assembles NBYTES MSB-first data bytes plus an XOR
// checksum into ival, publishing only verified words, and counts stream errors.
module ival_loader #(
  parameter int                  NBYTES  = 4,
  parameter int                  TIMEOUT = 255,
  parameter int                  ERRW    = 8,
  parameter logic [8*NBYTES-1:0] RST_VAL = '0
) (
  input  logic                  sysclk,
  input  logic                  reset,
  input  logic [7:0]            din,
  input  logic                  din_sof,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic                  ival_hold,
  output logic [8*NBYTES-1:0]   ival,
  output logic                  ival_upd,
  output logic [ERRW-1:0]       err_cnt,
  output logic                  busy
);

  localparam int CW = $clog2(NBYTES + 1);
  localparam int GW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int LW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] CNT_PRE  = CW'(NBYTES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT - 1);
  localparam logic [LW-1:0] TOP_LANE = LW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, DATA, CSUM} state_t;

  state_t                  state, state_nxt;
  logic [NBYTES-1:0][7:0]  shadow;
  logic [7:0]              csum;
  logic [CW-1:0]           cnt;
  logic [GW-1:0]           gap;
  logic [LW-1:0]           lane;
  logic                    accept, timeout_hit;
  logic                    start, append, commit, err_inc, commit_q;

  assign din_ready   = ~reset & ~ival_hold;
  assign accept      = din_valid & din_ready;
  assign busy        = (state != IDLE);
  // The gap counter tops out one short of TIMEOUT: the abort happens on the
  // edge that would have made it reach TIMEOUT.
  assign timeout_hit = busy & ~accept & ~ival_hold & (gap == GAP_LAST);
  assign lane        = TOP_LANE - LW'(cnt);

  always_ff @(posedge sysclk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    append    = 1'b0;
    commit    = 1'b0;
    err_inc   = 1'b0;
    if (accept) begin
      if (din_sof) begin
        start     = 1'b1;
        err_inc   = (state != IDLE);
        state_nxt = (NBYTES == 1) ? CSUM : DATA;
      end else begin
        unique case (state)
          IDLE: err_inc = 1'b1;
          DATA: begin
            append = 1'b1;
            if (cnt == CNT_PRE) state_nxt = CSUM;
          end
          CSUM: begin
            state_nxt = IDLE;
            if (din == csum) commit  = 1'b1;
            else             err_inc = 1'b1;
          end
          default: state_nxt = IDLE;
        endcase
      end
    end else if (timeout_hit) begin
      state_nxt = IDLE;
      err_inc   = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so the commit
  // below publishes the shadow as it stood before a same-edge sof overwrites it.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      shadow   <= '0;
      csum     <= '0;
      cnt      <= '0;
      gap      <= '0;
      ival     <= RST_VAL;
      ival_upd <= 1'b0;
      err_cnt  <= '0;
      commit_q <= 1'b0;
    end else begin
      commit_q <= commit;
      ival_upd <= commit_q;
      if (commit_q) ival <= shadow;

      if (start) begin
        shadow[NBYTES-1] <= din;
        csum             <= din;
        cnt              <= CW'(1);
      end else if (append) begin
        shadow[lane] <= din;
        csum         <= csum ^ din;
        cnt          <= cnt + 1'b1;
      end

      if (accept || !busy || timeout_hit) gap <= '0;
      else if (!ival_hold)                gap <= gap + 1'b1;

      if (err_inc && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ival_loader.sv
// Directed bench for ival_loader: framing, checksum, restart, timeout,
// hold stalls, error saturation and mid-frame reset.
module tb_ival_loader;

  logic        sysclk = 1'b0;
  logic        reset;
  logic [7:0]  din;
  logic        din_sof;
  logic        din_valid;
  logic        din_ready;
  logic        ival_hold;
  logic [31:0] ival;
  logic        ival_upd;
  logic [7:0]  err_cnt;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;

  ival_loader dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .din       (din),
    .din_sof   (din_sof),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .ival_hold (ival_hold),
    .ival      (ival),
    .ival_upd  (ival_upd),
    .err_cnt   (err_cnt),
    .busy      (busy)
  );

  always #5 sysclk = ~sysclk;

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  // Presents one byte for a single cycle; returns 1 time unit after its accept edge.
  task automatic send(input logic [7:0] b, input logic sof);
    din       = b;
    din_sof   = sof;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    din_sof   = 1'b0;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    din_valid = 1'b0;
    din_sof   = 1'b0;
    ival_hold = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    vectors++;
    if (ival !== 32'h0) begin
      miscompares++; $display("FAIL reset_ival: got %h want %h", ival, 32'h0);
    end
    vectors++;
    if ({ival_upd, busy, din_ready} !== 3'b000) begin
      miscompares++; $display("FAIL reset_flags: got %b want 000", {ival_upd, busy, din_ready});
    end
    vectors++;
    if (err_cnt !== 8'h00) begin
      miscompares++; $display("FAIL reset_err: got %h want 00", err_cnt);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (din_ready !== 1'b1) begin
      miscompares++; $display("FAIL ready_after_reset: got %b want 1", din_ready);
    end
  endtask

  task automatic test_good_frame();
    send(8'h12, 1'b1);
    send(8'h34, 1'b0);
    send(8'h56, 1'b0);
    send(8'h78, 1'b0);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++; $display("FAIL good_busy: got %b want 1", busy);
    end
    send(8'h08, 1'b0);
    vectors++;
    if ({ival_upd, ival} !== {1'b0, 32'h0}) begin
      miscompares++; $display("FAIL good_early: got upd=%b ival=%h want upd=0 ival=00000000", ival_upd, ival);
    end
    tick();
    vectors++;
    if ({ival_upd, ival} !== {1'b1, 32'h12345678}) begin
      miscompares++; $display("FAIL good_update: got upd=%b ival=%h want upd=1 ival=12345678", ival_upd, ival);
    end
    tick();
    vectors++;
    if ({ival_upd, busy, err_cnt} !== {1'b0, 1'b0, 8'h00}) begin
      miscompares++; $display("FAIL good_after: got upd=%b busy=%b err=%h want 0 0 00", ival_upd, busy, err_cnt);
    end
  endtask

  task automatic test_bad_csum();
    logic seen_upd;
    seen_upd = 1'b0;
    send(8'h12, 1'b1);
    send(8'h34, 1'b0);
    send(8'h56, 1'b0);
    send(8'h78, 1'b0);
    send(8'hFF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      seen_upd = seen_upd | ival_upd;
      tick();
    end
    vectors++;
    if ({seen_upd, ival} !== {1'b0, 32'h12345678}) begin
      miscompares++; $display("FAIL badcsum_ival: got upd=%b ival=%h want upd=0 ival=12345678", seen_upd, ival);
    end
    vectors++;
    if (err_cnt !== 8'h01) begin
      miscompares++; $display("FAIL badcsum_err: got %h want 01", err_cnt);
    end
  endtask

  task automatic test_restart();
    do_reset();
    send(8'hAA, 1'b1);
    send(8'hBB, 1'b0);
    send(8'h01, 1'b1);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b0);
    send(8'h04, 1'b0);
    tick();
    vectors++;
    if ({ival_upd, ival, err_cnt} !== {1'b1, 32'h01020304, 8'h01}) begin
      miscompares++; $display("FAIL restart: got upd=%b ival=%h err=%h want 1 01020304 01", ival_upd, ival, err_cnt);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send(8'hDE, 1'b1);
    send(8'hAD, 1'b0);
    send(8'hBE, 1'b0);
    send(8'hEF, 1'b0);
    send(8'h22, 1'b0);
    send(8'h01, 1'b1);
    vectors++;
    if ({ival_upd, ival, busy} !== {1'b1, 32'hDEADBEEF, 1'b1}) begin
      miscompares++; $display("FAIL b2b_first: got upd=%b ival=%h busy=%b want 1 deadbeef 1", ival_upd, ival, busy);
    end
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b0);
    send(8'h04, 1'b0);
    tick();
    vectors++;
    if ({ival_upd, ival, err_cnt} !== {1'b1, 32'h01020304, 8'h00}) begin
      miscompares++; $display("FAIL b2b_second: got upd=%b ival=%h err=%h want 1 01020304 00", ival_upd, ival, err_cnt);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    send(8'h11, 1'b1);
    repeat (254) tick();
    vectors++;
    if ({busy, err_cnt} !== {1'b1, 8'h00}) begin
      miscompares++; $display("FAIL timeout_early: got busy=%b err=%h want 1 00", busy, err_cnt);
    end
    tick();
    vectors++;
    if ({busy, err_cnt} !== {1'b0, 8'h01}) begin
      miscompares++; $display("FAIL timeout_abort: got busy=%b err=%h want 0 01", busy, err_cnt);
    end
    send(8'h55, 1'b0);
    vectors++;
    if ({busy, err_cnt} !== {1'b0, 8'h02}) begin
      miscompares++; $display("FAIL timeout_nosof: got busy=%b err=%h want 0 02", busy, err_cnt);
    end
  endtask

  task automatic test_hold();
    do_reset();
    send(8'h12, 1'b1);
    send(8'h34, 1'b0);
    ival_hold = 1'b1;
    din       = 8'h56;
    din_valid = 1'b1;
    repeat (300) tick();
    vectors++;
    if ({din_ready, busy, err_cnt} !== {1'b0, 1'b1, 8'h00}) begin
      miscompares++; $display("FAIL hold_data: got ready=%b busy=%b err=%h want 0 1 00", din_ready, busy, err_cnt);
    end
    ival_hold = 1'b0;
    tick();
    din_valid = 1'b0;
    send(8'h78, 1'b0);
    ival_hold = 1'b1;
    din       = 8'h08;
    din_valid = 1'b1;
    repeat (300) tick();
    vectors++;
    if ({ival_upd, ival, busy, err_cnt} !== {1'b0, 32'h0, 1'b1, 8'h00}) begin
      miscompares++; $display("FAIL hold_csum: got upd=%b ival=%h busy=%b err=%h want 0 00000000 1 00", ival_upd, ival, busy, err_cnt);
    end
    ival_hold = 1'b0;
    tick();
    din_valid = 1'b0;
    tick();
    vectors++;
    if ({ival_upd, ival, err_cnt} !== {1'b1, 32'h12345678, 8'h00}) begin
      miscompares++; $display("FAIL hold_release: got upd=%b ival=%h err=%h want 1 12345678 00", ival_upd, ival, err_cnt);
    end
  endtask

  task automatic test_saturate_and_reset();
    for (int i = 0; i < 300; i++) begin
      din       = 8'(i);
      din_sof   = 1'b0;
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    tick();
    vectors++;
    if (err_cnt !== 8'hFF) begin
      miscompares++; $display("FAIL saturate: got %h want ff", err_cnt);
    end
    send(8'h9A, 1'b1);
    send(8'hBC, 1'b0);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++; $display("FAIL midframe_busy: got %b want 1", busy);
    end
    do_reset();
    vectors++;
    if ({ival, ival_upd, busy, err_cnt} !== {32'h0, 1'b0, 1'b0, 8'h00}) begin
      miscompares++; $display("FAIL midframe_reset: got ival=%h upd=%b busy=%b err=%h want 00000000 0 0 00", ival, ival_upd, busy, err_cnt);
    end
    send(8'h55, 1'b0);
    vectors++;
    if (err_cnt !== 8'h01) begin
      miscompares++; $display("FAIL post_reset_err: got %h want 01", err_cnt);
    end
  endtask

  initial begin
    reset     = 1'b1;
    din       = 8'h00;
    din_sof   = 1'b0;
    din_valid = 1'b0;
    ival_hold = 1'b0;
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_restart();
    test_back_to_back();
    test_timeout();
    test_hold();
    test_saturate_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
